pc_redirect_unit: RTL and testbench

Program-counter stage fed directly by BranchControl's final_wire (BranchTaken here) and by the EX-stage jump decode.
Holds the fetch PC and chooses each next PC from sequential +4, branch target, jump target or jump-register address.
When the pipeline is stalled or instruction memory is not ready, a redirect is buffered and applied on the next advance.
Flush pulses to the IF/ID and ID/EX registers on every accepted redirect.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/branch_target_calc.sv | 37 +++
 rtl/pc_redirect_unit.sv | 113 +++++++++++
 tb/tb_pc_redirect_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset PC, PC increment, redirect
// source encoding and PC-stage FSM state encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Redirect source, listed from lowest to highest priority
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_JR     = 2'd3
    } redir_src_e;

    // PC-stage FSM states
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Sign-extended, word-scaled branch displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect target selection for the PC stage.
// Priority is JR > J/JAL > taken branch.
module branch_target_calc
    import mips_pkg::*;
(
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic        jump_reg_i,
    input  logic [31:0] branch_base_pc_i,
    input  logic [15:0] branch_imm_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] jump_reg_addr_i,
    output logic [31:0] target_o,
    output redir_src_e  src_o,
    output logic        misalign_o
);

    // Pick the highest-priority redirect and form its target address
    always_comb begin
        target_o   = '0;
        src_o      = REDIR_NONE;
        misalign_o = 1'b0;
        if (jump_reg_i) begin
            src_o      = REDIR_JR;
            // Low bits are dropped; the misalignment is reported, not trapped
            target_o   = {jump_reg_addr_i[31:2], 2'b00};
            misalign_o = |jump_reg_addr_i[1:0];
        end else if (jump_i) begin
            src_o    = REDIR_JUMP;
            target_o = {branch_base_pc_i[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            src_o    = REDIR_BRANCH;
            target_o = branch_base_pc_i + branch_offset(branch_imm_i);
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with redirect buffering. A redirect that arrives while
// fetch cannot advance is parked and applied on the next advance; every
// accepted redirect produces exactly one Flush pulse.
module pc_redirect_unit
    import mips_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              ImemReady,
    input  logic              BranchTaken,
    input  logic              Jump,
    input  logic              JumpReg,
    input  logic [ADDR_W-1:0] BranchBasePC,
    input  logic [15:0]       BranchImm,
    input  logic [25:0]       JumpIndex,
    input  logic [ADDR_W-1:0] JumpRegAddr,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              Flush,
    output logic              RedirectPending,
    output logic              AddrFault
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [0:0]        state_q, state_d;
    logic              flush_q, flush_d;
    logic              fault_q, fault_d;

    logic [31:0] target;
    redir_src_e  src;
    logic        misalign;
    logic        advance;
    logic        req;

    branch_target_calc u_target (
        .branch_taken_i   (BranchTaken),
        .jump_i           (Jump),
        .jump_reg_i       (JumpReg),
        .branch_base_pc_i (BranchBasePC),
        .branch_imm_i     (BranchImm),
        .jump_index_i     (JumpIndex),
        .jump_reg_addr_i  (JumpRegAddr),
        .target_o         (target),
        .src_o            (src),
        .misalign_o       (misalign)
    );

    assign advance = ImemReady & ~Stall;
    assign req     = (src != REDIR_NONE);

    // Next-state logic: sequential fetch, direct redirect, or park/apply pending target
    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        state_d = state_q;
        flush_d = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (req) begin
                    flush_d = 1'b1;
                    fault_d = misalign;
                    if (advance) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = ST_PENDING;
                    end
                end else if (advance) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            ST_PENDING: begin
                // New requests here come from a path that is already squashed
                if (advance) begin
                    pc_d    = pend_q;
                    pend_d  = '0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            state_q <= ST_RUN;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
        end
    end

    assign PC              = pc_q;
    assign PCPlus4         = pc_q + PC_INC;
    assign Flush           = flush_q;
    assign AddrFault       = fault_q;
    assign RedirectPending = (state_q == ST_PENDING);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with an expected-result scoreboard.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic        ImemReady;
    logic        BranchTaken;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] BranchBasePC;
    logic [15:0] BranchImm;
    logic [25:0] JumpIndex;
    logic [31:0] JumpRegAddr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Flush;
    logic        RedirectPending;
    logic        AddrFault;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        pend;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Stall           (Stall),
        .ImemReady       (ImemReady),
        .BranchTaken     (BranchTaken),
        .Jump            (Jump),
        .JumpReg         (JumpReg),
        .BranchBasePC    (BranchBasePC),
        .BranchImm       (BranchImm),
        .JumpIndex       (JumpIndex),
        .JumpRegAddr     (JumpRegAddr),
        .PC              (PC),
        .PCPlus4         (PCPlus4),
        .Flush           (Flush),
        .RedirectPending (RedirectPending),
        .AddrFault       (AddrFault)
    );

    task automatic chk32(input string tag, input string fld, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, record the expected post-edge outputs, then check
    task automatic step(input string tag, input logic r, input logic st, input logic rdy,
                        input logic bt, input logic j, input logic jr,
                        input logic [31:0] base, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] jra,
                        input logic [31:0] e_pc, input logic e_f, input logic e_p,
                        input logic e_af);
        exp_t e;
        rst = r; Stall = st; ImemReady = rdy;
        BranchTaken = bt; Jump = j; JumpReg = jr;
        BranchBasePC = base; BranchImm = imm; JumpIndex = idx; JumpRegAddr = jra;
        e.tag = tag; e.pc = e_pc; e.flush = e_f; e.pend = e_p; e.fault = e_af;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s.scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk32(e.tag, "PC", PC, e.pc);
            chk32(e.tag, "PCPlus4", PCPlus4, e.pc + 32'd4);
            chk32(e.tag, "Flush", {31'd0, Flush}, {31'd0, e.flush});
            chk32(e.tag, "Pending", {31'd0, RedirectPending}, {31'd0, e.pend});
            chk32(e.tag, "AddrFault", {31'd0, AddrFault}, {31'd0, e.fault});
        end
    endtask

    // Shorthand for a cycle with no redirect request
    task automatic idle(input string tag, input logic r, input logic st, input logic rdy,
                        input logic [31:0] e_pc, input logic e_f, input logic e_p);
        step(tag, r, st, rdy, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0,
             e_pc, e_f, e_p, 1'b0);
    endtask

    initial begin
        // Reset for two cycles
        idle("rst0", 1, 0, 1, 32'h0, 0, 0);
        idle("rst1", 1, 0, 1, 32'h0, 0, 0);
        // Sequential fetch
        idle("seq4", 0, 0, 1, 32'h4, 0, 0);
        idle("seq8", 0, 0, 1, 32'h8, 0, 0);
        idle("seqC", 0, 0, 1, 32'hC, 0, 0);
        // Jump to 0x100
        step("j100", 0, 0, 1, 0, 1, 0, 32'h10, 16'h0, 26'h40, 32'h0, 32'h100, 1, 0, 0);
        idle("seq104", 0, 0, 1, 32'h104, 0, 0);
        // Backward branch: 0x104 + (-2 << 2) = 0xFC
        step("brback", 0, 0, 1, 1, 0, 0, 32'h104, 16'hFFFE, 26'h0, 32'h0,
             32'hFC, 1, 0, 0);
        idle("seq100", 0, 0, 1, 32'h100, 0, 0);
        // Jump beats branch in the same cycle
        step("jwins", 0, 0, 1, 1, 1, 0, 32'h9000_0010, 16'h0010, 26'h40, 32'h0,
             32'h9000_0100, 1, 0, 0);
        idle("seqj", 0, 0, 1, 32'h9000_0104, 0, 0);
        // Branch under stall gets parked; target 0x200 + 0x40
        step("stbr", 0, 1, 1, 1, 0, 0, 32'h200, 16'h0010, 26'h0, 32'h0,
             32'h9000_0104, 1, 1, 0);
        step("stjign", 0, 1, 1, 0, 1, 0, 32'h10, 16'h0, 26'h3FF, 32'h0,
             32'h9000_0104, 0, 1, 0);
        idle("sthold", 0, 1, 1, 32'h9000_0104, 0, 1);
        idle("imemnr", 0, 0, 0, 32'h9000_0104, 0, 1);
        idle("apply", 0, 0, 1, 32'h240, 0, 0);
        idle("seq244", 0, 0, 1, 32'h244, 0, 0);
        // Misaligned JR: address cleared, one fault pulse
        step("jrmis", 0, 0, 1, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h0000_1003,
             32'h1000, 1, 0, 1);
        idle("seq1004", 0, 0, 1, 32'h1004, 0, 0);
        // Aligned JR to the top word, then wrap
        step("jrtop", 0, 0, 1, 1, 1, 1, 32'h0, 16'h0, 26'h1, 32'hFFFF_FFFC,
             32'hFFFF_FFFC, 1, 0, 0);
        idle("wrap", 0, 0, 1, 32'h0, 0, 0);
        idle("seq4b", 0, 0, 1, 32'h4, 0, 0);
        // Reset while a redirect is parked discards it
        step("pendrst", 0, 1, 1, 1, 0, 0, 32'h200, 16'h0010, 26'h0, 32'h0,
             32'h4, 1, 1, 0);
        idle("rstpend", 1, 0, 1, 32'h0, 0, 0);
        idle("postrst4", 0, 0, 1, 32'h4, 0, 0);
        idle("postrst8", 0, 0, 1, 32'h8, 0, 0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
